// File: rtl/wb_stage.sv
// wb_stage -- write-back stage of the 5-stage MIPS pipeline.
//
// Latches M-stage results into the M/W register, extracts and extends load
// data, selects the write-back source and drives the register-file write
// port. Also exports the W-stage destination/data for forwarding and keeps
// a retired-instruction counter.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   m_valid .. m_ldt    M-stage instruction fields
//   hold                freeze the W register and suppress the write
//   flush               load a bubble into W (wins over hold)
//   grf_we/a3/wd/pc     register-file write port (pc for trace)
//   w_fwd_a3/w_fwd_data forwarding view of the write (0 when no write)
//   retire_cnt          count of retired instructions, wraps at 2^CNT_W
//
// Optional macro WB_TRACE_EN: prints a simulation-only trace line
// "T@PC: $R <= DATA" at each edge that commits a register write.

module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_valid,
  input  logic [31:0]      m_pc,
  input  logic             m_we,
  input  logic [4:0]       m_a3,
  input  logic [1:0]       m_wsel,
  input  logic [31:0]      m_alu,
  input  logic [31:0]      m_rdata,
  input  logic [2:0]       m_ldt,
  input  logic             hold,
  input  logic             flush,
  output logic             grf_we,
  output logic [4:0]       grf_a3,
  output logic [31:0]      grf_wd,
  output logic [31:0]      grf_pc,
  output logic [4:0]       w_fwd_a3,
  output logic [31:0]      w_fwd_data,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC8 = 2'b10;

  localparam logic [2:0] LDT_LBU = 3'b001;
  localparam logic [2:0] LDT_LB  = 3'b010;
  localparam logic [2:0] LDT_LHU = 3'b011;
  localparam logic [2:0] LDT_LH  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_valid;
  logic             r_we;
  logic [4:0]       r_a3;
  logic [31:0]      r_pc;
  logic [1:0]       r_wsel;
  logic [31:0]      r_alu;
  logic [31:0]      r_rdata;
  logic [2:0]       r_ldt;
  logic [CNT_W-1:0] r_cnt;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_pc8;
  logic [31:0] w_wd_sel;
  logic        w_we;

  // M/W pipeline register: reset > flush > hold > capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_a3    <= 5'd0;
      r_pc    <= RESET_PC;
      r_wsel  <= 2'b00;
      r_alu   <= 32'd0;
      r_rdata <= 32'd0;
      r_ldt   <= 3'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_a3    <= 5'd0;
      r_pc    <= RESET_PC;
      r_wsel  <= 2'b00;
      r_alu   <= 32'd0;
      r_rdata <= 32'd0;
      r_ldt   <= 3'd0;
    end else if (!hold) begin
      r_valid <= m_valid;
      r_we    <= m_we;
      r_a3    <= m_a3;
      r_pc    <= m_pc;
      r_wsel  <= m_wsel;
      r_alu   <= m_alu;
      r_rdata <= m_rdata;
      r_ldt   <= m_ldt;
    end
  end

  // An instruction retires on the edge it leaves W without being held or
  // flushed, so a held instruction is counted once, on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_valid && !hold && !flush) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_alu[1:0])
      2'd0: w_byte = r_rdata[7:0];
      2'd1: w_byte = r_rdata[15:8];
      2'd2: w_byte = r_rdata[23:16];
      2'd3: w_byte = r_rdata[31:24];
      default: w_byte = r_rdata[7:0];
    endcase
    // halfword select ignores addr[0]
    w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
  end

  always_comb begin
    w_load = r_rdata;
    case (r_ldt)
      LDT_LBU: w_load = {24'd0, w_byte};
      LDT_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      LDT_LHU: w_load = {16'd0, w_half};
      LDT_LH:  w_load = {{16{w_half[15]}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  assign w_pc8 = r_pc + 32'd8;

  always_comb begin
    w_wd_sel = 32'd0;
    case (r_wsel)
      WSEL_ALU: w_wd_sel = r_alu;
      WSEL_MEM: w_wd_sel = w_load;
      WSEL_PC8: w_wd_sel = w_pc8;
      default:  w_wd_sel = 32'd0;
    endcase
  end

  // $0 is never written; a held instruction neither writes nor forwards
  assign w_we = r_valid & r_we & (r_a3 != 5'd0) & ~hold;

  assign grf_we     = w_we;
  assign grf_a3     = w_we ? r_a3 : 5'd0;
  assign grf_wd     = w_we ? w_wd_sel : 32'd0;
  assign grf_pc     = r_pc;
  assign w_fwd_a3   = grf_a3;
  assign w_fwd_data = grf_wd;
  assign retire_cnt = r_cnt;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (grf_we) begin
      $display("%0t@%h: $%0d <= %h", $time, grf_pc, grf_a3, grf_wd);
    end
  end
`else
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected writes are queued at issue
// time and a negedge monitor pops and compares each register-file write.

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [1:0]  m_wsel;
  logic [31:0] m_alu;
  logic [31:0] m_rdata;
  logic [2:0]  m_ldt;
  logic        hold;
  logic        flush;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [4:0]  w_fwd_a3;
  logic [31:0] w_fwd_data;
  logic [31:0] retire_cnt;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  wb_stage #(.RESET_PC(32'h0000_3000), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_pc(m_pc), .m_we(m_we), .m_a3(m_a3),
    .m_wsel(m_wsel), .m_alu(m_alu), .m_rdata(m_rdata), .m_ldt(m_ldt),
    .hold(hold), .flush(flush),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .w_fwd_a3(w_fwd_a3), .w_fwd_data(w_fwd_data), .retire_cnt(retire_cnt)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // write monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && grf_we === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got a3=%0d wd=%h pc=%h expected no write",
                 grf_a3, grf_wd, grf_pc);
      end else begin
        e = q.pop_front();
        chk("wr_a3", {27'd0, grf_a3}, {27'd0, e.a3});
        chk("wr_wd", grf_wd, e.wd);
        chk("wr_pc", grf_pc, e.pc);
        chk("fwd_a3", {27'd0, w_fwd_a3}, {27'd0, e.a3});
        chk("fwd_data", w_fwd_data, e.wd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [4:0] a3, input logic [1:0] wsel,
                       input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [2:0] ldt);
    m_valid = 1'b1; m_we = we; m_a3 = a3; m_wsel = wsel;
    m_pc = pc; m_alu = alu; m_rdata = rdata; m_ldt = ldt;
  endtask

  task automatic idle();
    m_valid = 1'b0; m_we = 1'b0; m_a3 = 5'd0; m_wsel = 2'b00;
    m_pc = 32'd0; m_alu = 32'd0; m_rdata = 32'd0; m_ldt = 3'd0;
  endtask

  task automatic push(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    exp_t e;
    e.a3 = a3; e.wd = wd; e.pc = pc;
    q.push_back(e);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_we"}, {31'd0, grf_we}, 32'd0);
    chk({tag, "_a3"}, {27'd0, grf_a3}, 32'd0);
    chk({tag, "_wd"}, grf_wd, 32'd0);
    chk({tag, "_fwd_a3"}, {27'd0, w_fwd_a3}, 32'd0);
    chk({tag, "_fwd_data"}, w_fwd_data, 32'd0);
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    idle();
    step(); step();
    reset = 1'b0;
    #1;
    chk_quiet("rst");
    chk("rst_pc", grf_pc, 32'h0000_3000);
    chk("rst_cnt", retire_cnt, 32'd0);

    // ALU write
    issue(1'b1, 5'd8, 2'b00, 32'h0000_3000, 32'h1234_5678, 32'd0, 3'd0);
    push(5'd8, 32'h1234_5678, 32'h0000_3000);
    step();
    idle();
    chk("alu_cnt_before", retire_cnt, 32'd0);
    step();
    chk("alu_cnt", retire_cnt, 32'd1);

    // loads, back to back
    issue(1'b1, 5'd1, 2'b01, 32'h0000_3004, 32'h0000_1003, RD, 3'b010);
    push(5'd1, 32'hFFFF_FF80, 32'h0000_3004); step();
    issue(1'b1, 5'd2, 2'b01, 32'h0000_3008, 32'h0000_1001, RD, 3'b001);
    push(5'd2, 32'h0000_007F, 32'h0000_3008); step();
    issue(1'b1, 5'd3, 2'b01, 32'h0000_300C, 32'h0000_1002, RD, 3'b100);
    push(5'd3, 32'hFFFF_80FF, 32'h0000_300C); step();
    issue(1'b1, 5'd4, 2'b01, 32'h0000_3010, 32'h0000_1000, RD, 3'b011);
    push(5'd4, 32'h0000_7F01, 32'h0000_3010); step();
    issue(1'b1, 5'd5, 2'b01, 32'h0000_3014, 32'h0000_1003, RD, 3'b000);
    push(5'd5, 32'h80FF_7F01, 32'h0000_3014); step();
    issue(1'b1, 5'd6, 2'b01, 32'h0000_3018, 32'h0000_1001, RD, 3'b111);
    push(5'd6, 32'h80FF_7F01, 32'h0000_3018); step();
    issue(1'b1, 5'd7, 2'b01, 32'h0000_301C, 32'h0000_1003, RD, 3'b100);
    push(5'd7, 32'hFFFF_80FF, 32'h0000_301C); step();
    idle();
    step();
    chk("load_cnt", retire_cnt, 32'd8);

    // link, wrap, reserved select, link to $0
    issue(1'b1, 5'd31, 2'b10, 32'h0000_3010, 32'h0000_0000, 32'd0, 3'd0);
    push(5'd31, 32'h0000_3018, 32'h0000_3010); step();
    issue(1'b1, 5'd30, 2'b10, 32'hFFFF_FFFC, 32'h0000_0000, 32'd0, 3'd0);
    push(5'd30, 32'h0000_0004, 32'hFFFF_FFFC); step();
    issue(1'b1, 5'd9, 2'b11, 32'h0000_3020, 32'h0000_DEAD, 32'd0, 3'd0);
    push(5'd9, 32'h0000_0000, 32'h0000_3020); step();
    issue(1'b1, 5'd0, 2'b10, 32'h0000_3010, 32'h0000_0000, 32'd0, 3'd0);
    step();
    idle();
    chk_quiet("r0");
    chk("r0_pc", grf_pc, 32'h0000_3010);
    step();
    chk("link_cnt", retire_cnt, 32'd12);

    // hold for three edges, then release
    issue(1'b1, 5'd12, 2'b00, 32'h0000_3040, 32'hCAFE_F00D, 32'd0, 3'd0);
    push(5'd12, 32'hCAFE_F00D, 32'h0000_3040);
    step();
    idle();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_we", {31'd0, grf_we}, 32'd0);
      chk("hold_fwd_a3", {27'd0, w_fwd_a3}, 32'd0);
      chk("hold_pc", grf_pc, 32'h0000_3040);
      chk("hold_cnt", retire_cnt, 32'd12);
      step();
    end
    hold = 1'b0;
    #1;
    chk("release_we", {31'd0, grf_we}, 32'd1);
    step();
    chk("release_cnt", retire_cnt, 32'd13);

    // flush together with hold, valid instruction in both W and M
    issue(1'b1, 5'd14, 2'b00, 32'h0000_3050, 32'h0000_0011, 32'd0, 3'd0);
    step();
    issue(1'b1, 5'd15, 2'b00, 32'h0000_3054, 32'h0000_0022, 32'd0, 3'd0);
    hold = 1'b1; flush = 1'b1;
    #1;
    chk("fh_we_pre", {31'd0, grf_we}, 32'd0);
    step();
    hold = 1'b0; flush = 1'b0;
    idle();
    #1;
    chk_quiet("flush");
    chk("flush_pc", grf_pc, 32'h0000_3000);
    chk("flush_cnt", retire_cnt, 32'd13);
    step();
    chk("flush_cnt2", retire_cnt, 32'd13);

    // reset while holding a pending write to $5
    issue(1'b1, 5'd5, 2'b00, 32'h0000_3060, 32'h0000_0055, 32'd0, 3'd0);
    step();
    idle();
    hold = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk_quiet("rsthold");
    chk("rsthold_pc", grf_pc, 32'h0000_3000);
    chk("rsthold_cnt", retire_cnt, 32'd0);
    reset = 1'b0; hold = 1'b0;
    step(); step();
    chk("rsthold_cnt2", retire_cnt, 32'd0);

    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
